pair_dist_sequencer: RTL and testbench

- Hardware sequencer for Program 2: computes the minimum and maximum absolute arithmetic distance over all unordered pairs of 32 signed 16-bit values held in data memory.
- Sits beside the data memory in `top_level` and owns its port for the duration of a run.
- Run flow: bulk-loads the operands, scans all 496 pairs through an abs-distance datapath, writes Min to bytes 66:67 and Max to bytes 68:69, then raises `done`.

---
 rtl/pair_dist_pkg.sv | 23 ++
 rtl/pair_dist_sequencer_abs_dist.sv | 19 +
 rtl/pair_dist_sequencer.sv | 148 ++++++++++++++
 tb/tb_pair_dist_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pair_dist_pkg.sv
// Shared types and constants for the pair-distance sequencer.
// Holds the FSM state encoding, default sizing and result byte addresses.
package pair_dist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_WR_MIN_H,
    S_WR_MIN_L,
    S_WR_MAX_H,
    S_WR_MAX_L,
    S_DONE
  } state_t;

  localparam int N_VALS_DEF    = 32;
  localparam int BASE_ADDR_DEF = 0;
  localparam int MIN_ADDR_DEF  = 66;
  localparam int MAX_ADDR_DEF  = 68;

  typedef logic [15:0] dist_t;

endpackage

// File: rtl/pair_dist_sequencer_abs_dist.sv
// Combinational |a - b| for signed 16-bit operands.
// The result is a 16-bit unsigned magnitude, so 65535 is representable.
module abs_dist
  import pair_dist_pkg::*;
(
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  output dist_t              d
);

  logic [16:0] diff;

  // Only the low 16 bits of the negation are needed; they depend on diff[15:0] alone.
  always_comb begin
    diff = {a[15], a} - {b[15], b};
    d    = diff[16] ? (16'd0 - diff[15:0]) : diff[15:0];
  end

endmodule

// File: rtl/pair_dist_sequencer.sv
// Loads N signed 16-bit operands from byte memory, scans every unordered pair
// for min/max absolute distance, and writes both results back big-endian.
module pair_dist_sequencer
  import pair_dist_pkg::*;
#(
  parameter int N_VALS    = N_VALS_DEF,
  parameter int BASE_ADDR = BASE_ADDR_DEF,
  parameter int MIN_ADDR  = MIN_ADDR_DEF,
  parameter int MAX_ADDR  = MAX_ADDR_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data,
  output dist_t      min_dist,
  output dist_t      max_dist,
  output logic [4:0] min_j,
  output logic [4:0] min_k,
  output logic [4:0] max_j,
  output logic [4:0] max_k
);

  localparam int BW = $clog2(2 * N_VALS);

  state_t        state, nxt;
  logic          start_q;
  logic [BW-1:0] bcnt;
  logic [4:0]    j, k;
  logic [15:0]   val [N_VALS];
  dist_t         d;
  logic          load_last, scan_last, first_pair;

  assign load_last  = (bcnt == BW'(2 * N_VALS - 1));
  assign scan_last  = (j == 5'(N_VALS - 2)) && (k == 5'(N_VALS - 1));
  assign first_pair = (j == '0) && (k == 5'd1);

  abs_dist u_abs_dist (
    .a (val[j]),
    .b (val[k]),
    .d (d)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (start) begin
      nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:     if (start_q) nxt = S_LOAD;
        S_LOAD:     if (load_last) nxt = S_SCAN;
        S_SCAN:     if (scan_last) nxt = S_WR_MIN_H;
        S_WR_MIN_H: nxt = S_WR_MIN_L;
        S_WR_MIN_L: nxt = S_WR_MAX_H;
        S_WR_MAX_H: nxt = S_WR_MAX_L;
        S_WR_MAX_L: nxt = S_DONE;
        S_DONE:     nxt = S_DONE;
        default:    nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    done        = 1'b0;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    unique case (state)
      S_LOAD:     mem_addr = 8'(BASE_ADDR) + 8'(bcnt);
      S_WR_MIN_H: begin mem_addr = 8'(MIN_ADDR);     mem_wr_en = 1'b1; mem_wr_data = min_dist[15:8]; end
      S_WR_MIN_L: begin mem_addr = 8'(MIN_ADDR + 1); mem_wr_en = 1'b1; mem_wr_data = min_dist[7:0];  end
      S_WR_MAX_H: begin mem_addr = 8'(MAX_ADDR);     mem_wr_en = 1'b1; mem_wr_data = max_dist[15:8]; end
      S_WR_MAX_L: begin mem_addr = 8'(MAX_ADDR + 1); mem_wr_en = 1'b1; mem_wr_data = max_dist[7:0];  end
      S_DONE:     done = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == S_LOAD) begin
      if (!bcnt[0]) val[bcnt[BW-1:1]][15:8] <= mem_rd_data;
      else          val[bcnt[BW-1:1]][7:0]  <= mem_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q  <= 1'b1;
      bcnt     <= '0;
      j        <= '0;
      k        <= '0;
      min_dist <= '1;
      max_dist <= '0;
      min_j    <= '0;
      min_k    <= '0;
      max_j    <= '0;
      max_k    <= '0;
    end else begin
      start_q <= start;
      unique case (state)
        S_IDLE: bcnt <= '0;
        S_LOAD: begin
          bcnt <= bcnt + 1'b1;
          if (load_last) begin
            j        <= '0;
            k        <= 5'd1;
            min_dist <= '1;
            max_dist <= '0;
            min_j    <= '0;
            min_k    <= '0;
            max_j    <= '0;
            max_k    <= '0;
          end
        end
        S_SCAN: begin
          // The first pair seeds both extremes so that equal-distance data
          // reports (0,1) for Max as well as Min; later pairs use strict compares.
          if (first_pair || d < min_dist) begin
            min_dist <= d;
            min_j    <= j;
            min_k    <= k;
          end
          if (first_pair || d > max_dist) begin
            max_dist <= d;
            max_j    <= j;
            max_k    <= k;
          end
          if (k == 5'(N_VALS - 1)) begin
            j <= j + 5'd1;
            k <= j + 5'd2;
          end else begin
            k <= k + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pair_dist_sequencer.sv
// Directed and randomized bench for pair_dist_sequencer with a byte-memory model
// and an exhaustive pair-search reference for min/max distance and first pair.
module tb_pair_dist_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        done;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rd_data;
  logic        mem_wr_en;
  logic [7:0]  mem_wr_data;
  logic [15:0] min_dist, max_dist;
  logic [4:0]  min_j, min_k, max_j, max_k;

  logic [7:0]         mem [256];
  logic signed [15:0] vals [32];
  int tests = 0;
  int fails = 0;
  int wr_count = 0;
  int stray = 0;
  int cyc;
  int wr0;

  always #5 clk = ~clk;

  pair_dist_sequencer #(.N_VALS(32), .BASE_ADDR(0), .MIN_ADDR(66), .MAX_ADDR(68)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .done        (done),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .min_dist    (min_dist),
    .max_dist    (max_dist),
    .min_j       (min_j),
    .min_k       (min_k),
    .max_j       (max_j),
    .max_k       (max_k)
  );

  assign mem_rd_data = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_addr] = mem_wr_data;
      wr_count++;
      if (mem_addr < 8'd66 || mem_addr > 8'd69) stray++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: find the extreme distances first, then the earliest pair attaining each.
  task automatic model(output int mn, output int mx, output int mnj, output int mnk,
                       output int mxj, output int mxk);
    int dd;
    mn = 65536; mx = -1;
    for (int a = 0; a < 32; a++)
      for (int b = a + 1; b < 32; b++) begin
        dd = int'(vals[a]) - int'(vals[b]);
        if (dd < 0) dd = -dd;
        if (dd < mn) mn = dd;
        if (dd > mx) mx = dd;
      end
    mnj = -1; mnk = -1; mxj = -1; mxk = -1;
    for (int a = 0; a < 32; a++)
      for (int b = a + 1; b < 32; b++) begin
        dd = int'(vals[a]) - int'(vals[b]);
        if (dd < 0) dd = -dd;
        if (dd == mn && mnj < 0) begin mnj = a; mnk = b; end
        if (dd == mx && mxj < 0) begin mxj = a; mxk = b; end
      end
  endtask

  task automatic load_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h5A;
    for (int i = 0; i < 32; i++) begin
      mem[2*i]   = vals[i][15:8];
      mem[2*i+1] = vals[i][7:0];
    end
    for (int i = 66; i < 70; i++) mem[i] = 8'hA5;
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    cyc = 1;
  endtask

  task automatic run_and_check(input string tag);
    int mn, mx, mnj, mnk, mxj, mxk;
    logic [15:0] exp_mn, exp_mx;
    load_mem();
    wr0 = wr_count;
    stray = 0;
    launch();
    while (cyc < 2000) begin
      @(negedge clk);
      if (done) break;
      @(posedge clk);
      cyc++;
    end
    check({tag, " latency"}, cyc, 565);
    model(mn, mx, mnj, mnk, mxj, mxk);
    exp_mn = 16'(mn);
    exp_mx = 16'(mx);
    check({tag, " min_dist"}, min_dist, exp_mn);
    check({tag, " min_j"}, min_j, mnj);
    check({tag, " min_k"}, min_k, mnk);
    check({tag, " max_dist"}, max_dist, exp_mx);
    check({tag, " max_j"}, max_j, mxj);
    check({tag, " max_k"}, max_k, mxk);
    check({tag, " mem66_67"}, {mem[66], mem[67]}, exp_mn);
    check({tag, " mem68_69"}, {mem[68], mem[69]}, exp_mx);
    check({tag, " writes"}, wr_count - wr0, 4);
    check({tag, " stray"}, stray, 0);
    repeat (10) @(negedge clk);
    check({tag, " hold_done"}, done, 1'b1);
    check({tag, " hold_writes"}, wr_count - wr0, 4);
    start = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " done_drop"}, done, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst done", done, 1'b0);
    check("rst wr_en", mem_wr_en, 1'b0);
    check("rst addr", mem_addr, 8'h00);
    check("rst wdata", mem_wr_data, 8'h00);
    check("rst min", min_dist, 16'hFFFF);
    check("rst max", max_dist, 16'h0000);
    check("rst idx", {min_j, min_k, max_j, max_k}, 20'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle done", done, 1'b0);

    for (int i = 0; i < 32; i++) vals[i] = 16'(100 * i);
    run_and_check("ramp");

    for (int i = 0; i < 32; i++) vals[i] = -16'sd7;
    run_and_check("const");

    for (int i = 0; i < 32; i++) vals[i] = 16'sd0;
    vals[5]  = -16'sd32768;
    vals[20] = 16'sd32767;
    run_and_check("extreme");

    // Abort mid-SCAN at cycle 300.
    for (int i = 0; i < 32; i++) vals[i] = 16'(100 * i);
    load_mem();
    wr0 = wr_count;
    launch();
    while (cyc < 300) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    check("abort done", done, 1'b0);
    check("abort wr_en", mem_wr_en, 1'b0);
    repeat (600) @(negedge clk);
    check("abort writes", wr_count - wr0, 0);
    check("abort mem", {mem[66], mem[67], mem[68], mem[69]}, 32'hA5A5A5A5);
    check("abort done_late", done, 1'b0);
    check("abort addr", mem_addr, 8'h00);

    // Reset mid-LOAD at cycle 40, then a clean relaunch.
    load_mem();
    wr0 = wr_count;
    launch();
    while (cyc < 40) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rstrun min", min_dist, 16'hFFFF);
    repeat (3) @(negedge clk);
    check("rstrun done", done, 1'b0);
    check("rstrun writes", wr_count - wr0, 0);
    run_and_check("ramp_after_reset");

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 32; i++) vals[i] = 16'($urandom);
      if (r == 3) vals[$urandom_range(0, 31)] = vals[0];
      run_and_check($sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
